wts_bus_initiator: RTL and testbench

- Bus master for the OCM-style req/ack slave bus; drives req/wrt/adr/dbo and samples dbi/ack.
- Used as the host-side driver of the wave table sound slot in standalone and test builds.
- Commands are queued in a small FIFO and issued one at a time, with full ack handshake.
- Results are returned on a one-cycle response strobe; an optional timeout aborts a stuck access.

---
 rtl/wts_bus_initiator.sv | 196 +++++++++++++++++++
 tb/tb_wts_bus_initiator.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_bus_initiator.sv
// wts_bus_initiator: OCM-style req/ack bus master with a small command FIFO.
// Queued commands are issued one at a time with a full ack handshake.
// Each completion raises rsp_valid for one cycle. The rsp_wrt, rsp_data and
// rsp_timeout fields hold until the next completion.
// Build option: define WTS_INIT_TIMEOUT_EN to abort an access that is still
// unacknowledged when the ISSUE counter reaches TIMEOUT.
module wts_bus_initiator #(
    parameter int FIFO_AW = 2,
    parameter int TIMEOUT = 63
) (
    input  logic        clk21m,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wrt,
    input  logic [15:0] cmd_adr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic        rsp_wrt,
    output logic [7:0]  rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        req,
    output logic        wrt,
    output logic [15:0] adr,
    output logic [7:0]  dbo,
    input  logic [7:0]  dbi,
    input  logic        ack
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RECOVER
    } state_t;

    typedef struct packed {
        logic        wrt;
        logic [15:0] adr;
        logic [7:0]  data;
    } cmd_t;

    cmd_t               fifo_mem [DEPTH];
    cmd_t               head;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_next;
    logic               push;
    logic               pop;
    logic               done;
    logic               done_timeout;
    state_t             state;
    state_t             state_next;

    // cmd_ready is a register, so a full FIFO refuses a push even in a cycle that also pops.
    assign push = cmd_valid & cmd_ready;
    assign head = fifo_mem[rd_ptr];
    assign busy = (count != '0) || (state != ST_IDLE);

    // Command storage: written on push, read at the head pointer.
    // NOTE: storage has no reset; the pointers and count decide what is valid,
    // so clearing the array would only add reset fan-out.
    always_ff @(posedge clk21m) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{wrt: cmd_wrt, adr: cmd_adr, data: cmd_data};
        end
    end

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO pointers (wrap naturally at DEPTH), count and the registered ready flag.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            cmd_ready <= (count_next != FULL_COUNT);
        end
    end

`ifdef WTS_INIT_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [7:0] to_cnt;

    // Counts unacknowledged ISSUE cycles, cleared at each pop, saturating at 255.
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (pop) begin
            to_cnt <= '0;
        end else if (state == ST_ISSUE && !ack && to_cnt != 8'hFF) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    // Keeps TIMEOUT referenced so both builds share one parameter list.
    localparam int unused_timeout = TIMEOUT;
`endif

    // FSM state register.
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state, FIFO pop and completion decode; ack only matters in ISSUE.
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        done         = 1'b0;
        done_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ack) begin
                    done       = 1'b1;
                    state_next = ST_RECOVER;
                end
`ifdef WTS_INIT_TIMEOUT_EN
                else if (to_cnt == TIMEOUT_C) begin
                    done         = 1'b1;
                    done_timeout = 1'b1;
                    state_next   = ST_RECOVER;
                end
`endif
            end
            ST_RECOVER: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Bus drive: load from the FIFO head on pop and hold until the access ends.
    // A completed access is reported in the following cycle.
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            req       <= 1'b0;
            wrt       <= 1'b0;
            adr       <= '0;
            dbo       <= '0;
            rsp_valid <= 1'b0;
            rsp_wrt   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= done;
            if (pop) begin
                req <= 1'b1;
                wrt <= head.wrt;
                adr <= head.adr;
                dbo <= head.data;
            end else if (done) begin
                req <= 1'b0;
            end
            if (done) begin
                rsp_wrt  <= wrt;
                rsp_data <= done_timeout ? 8'hFF : (wrt ? 8'h00 : dbi);
            end
        end
    end

`ifdef WTS_INIT_TIMEOUT_EN
    // Timeout flag of the most recent completion.
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset)     rsp_timeout <= 1'b0;
        else if (done) rsp_timeout <= done_timeout;
    end
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wts_bus_initiator.sv
// tb_wts_bus_initiator: directed plus random stimulus for wts_bus_initiator.
// A small slave answers req with a programmable ack latency. A queue of
// accepted commands, holding the response each one should produce, is the
// reference model.
module tb_wts_bus_initiator;

    logic        clk21m;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wrt;
    logic [15:0] cmd_adr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_wrt;
    logic [7:0]  rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic        req;
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  dbo;
    logic [7:0]  dbi;
    logic        ack;

    typedef struct {
        logic        wrt;
        logic [15:0] adr;
        logic [7:0]  data;
        logic [7:0]  exp_data;
        logic        exp_to;
    } exp_t;

    exp_t exp_q[$];

    int n_checks     = 0;
    int n_fail       = 0;
    int rsp_cnt      = 0;
    int req_len      = 0;
    int last_req_len = 0;
    int low_cnt      = 0;
    int last_gap     = 0;
    int min_gap      = 1000;

    bit slave_en  = 1'b1;
    bit rand_lat  = 1'b0;
    bit stray_ack = 1'b0;
    int slave_lat = 1;

    wts_bus_initiator dut (
        .clk21m      (clk21m),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wrt     (cmd_wrt),
        .cmd_adr     (cmd_adr),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_wrt     (rsp_wrt),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .req         (req),
        .wrt         (wrt),
        .adr         (adr),
        .dbo         (dbo),
        .dbi         (dbi),
        .ack         (ack)
    );

    initial begin
        clk21m = 1'b0;
        forever #5 clk21m = ~clk21m;
    end

    // Read data the slave returns for an address.
    function automatic logic [7:0] model_dbi(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'hDB;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk21m);
        #1;
    endtask

    // Hold a command for up to 'budget' cycles; it is accepted in the first
    // cycle that shows cmd_ready=1.
    task automatic push(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input bit will_to, input int budget, output bit acc);
        exp_t e;
        int   n;
        n   = 0;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_wrt   = w;
        cmd_adr   = a;
        cmd_data  = d;
        while (!acc && n < budget) begin
            if (cmd_ready) begin
                acc        = 1'b1;
                e.wrt      = w;
                e.adr      = a;
                e.data     = d;
                e.exp_to   = will_to;
                e.exp_data = will_to ? 8'hFF : (w ? 8'h00 : model_dbi(a));
                exp_q.push_back(e);
            end
            step();
            n++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (rsp_cnt < target && n < budget) begin
            step();
            n++;
        end
        check("rsp_arrival", rsp_cnt, target);
    endtask

    // Slave: ack once req has been high for latency+1 samples; drive stray_ack while req is low.
    initial begin : slave
        int hi;
        int lat;
        hi  = 0;
        lat = 0;
        ack = 1'b0;
        dbi = 8'h00;
        forever begin
            @(negedge clk21m);
            if (reset || !req) begin
                hi  = 0;
                ack = stray_ack;
                dbi = 8'($urandom);
            end else begin
                if (hi == 0) lat = rand_lat ? int'($urandom_range(0, 4)) : slave_lat;
                hi++;
                ack = slave_en && (hi >= lat + 1);
                dbi = ack ? model_dbi(adr) : 8'($urandom);
            end
        end
    end

    // Monitor: bus contents against the in-flight command, req timing, and responses in push order.
    initial begin : monitor
        bit   prev_req;
        bit   prev_rsp;
        exp_t e;
        prev_req = 1'b0;
        prev_rsp = 1'b0;
        forever begin
            @(negedge clk21m);
            if (reset) begin
                prev_req = 1'b0;
                prev_rsp = 1'b0;
                req_len  = 0;
                low_cnt  = 0;
            end else begin
                if (req) begin
                    if (!prev_req) begin
                        last_gap = low_cnt;
                        if (low_cnt < min_gap) min_gap = low_cnt;
                        low_cnt = 0;
                    end
                    req_len++;
                    check("req_has_cmd", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        check("bus_wrt_adr", {wrt, adr}, {exp_q[0].wrt, exp_q[0].adr});
                        if (exp_q[0].wrt) check("bus_dbo", dbo, exp_q[0].data);
                    end
                end else begin
                    if (prev_req) begin
                        last_req_len = req_len;
                        req_len      = 0;
                    end
                    low_cnt++;
                end
                if (rsp_valid) begin
                    check("rsp_single_pulse", prev_rsp, 0);
                    check("rsp_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rsp_fields", {rsp_wrt, rsp_timeout, rsp_data},
                              {e.wrt, e.exp_to, e.exp_data});
                        rsp_cnt++;
                    end
                end
                prev_req = req;
                prev_rsp = rsp_valid;
            end
        end
    end

    initial begin : stimulus
        bit acc;
        int rc;
        int n;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wrt   = 1'b0;
        cmd_adr   = '0;
        cmd_data  = '0;
        #1 reset  = 1'b1;
        repeat (3) step();

        // Reset values.
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_req", req, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_bus", {wrt, adr, dbo}, 0);
        check("rst_rsp", {rsp_wrt, rsp_timeout, rsp_data}, 0);
        reset = 1'b0;
        repeat (2) step();

        // Single write, ack one cycle after req rises.
        slave_lat = 1;
        push(1'b1, 16'h9800, 8'h5A, 1'b0, 1, acc);
        check("wr_accept", acc, 1);
        wait_drain(50);
        check("wr_req_len", last_req_len, 2);
        step();
        check("wr_busy_after", busy, 0);

        // Read with 10-cycle latency.
        slave_lat = 10;
        push(1'b0, 16'h9880, 8'h11, 1'b0, 1, acc);
        wait_drain(100);
        check("rd_busy_in_recover", busy, 1);
        check("rd_req_len", last_req_len, 11);
        step();
        check("rd_busy_after", busy, 0);
        check("rd_rsp_strobe_end", rsp_valid, 0);
        check("rd_rsp_data_hold", {rsp_wrt, rsp_data}, {1'b0, 8'hC3});

        // Stray ack pulse in IDLE.
        rc = rsp_cnt;
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        repeat (5) step();
        check("stray_no_rsp", rsp_cnt, rc);
        check("stray_no_busy", busy, 0);

        // Ack held high through IDLE; the read still needs its own ack.
        stray_ack = 1'b1;
        repeat (2) step();
        slave_lat = 3;
        push(1'b0, 16'h1234, 8'h00, 1'b0, 1, acc);
        wait_drain(50);
        check("held_ack_req_len", last_req_len, 4);
        stray_ack = 1'b0;
        repeat (2) step();

        // FIFO full: one access in flight plus four queued, the sixth refused.
        slave_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(1'b1, 16'h9000 + 16'(i), 8'(i * 17), 1'b0, 1, acc);
            check("full_accept", acc, (i < 5) ? 1 : 0);
        end
        check("full_cmd_ready", cmd_ready, 0);
        rc = rsp_cnt;
        min_gap   = 1000;
        slave_lat = 0;
        slave_en  = 1'b1;
        push(1'b0, 16'hABCD, 8'h00, 1'b0, 100, acc);
        check("full_late_accept", acc, 1);
        wait_drain(200);
        check("b2b_rsp_count", rsp_cnt - rc, 6);
        check("b2b_req_low_gap", min_gap, 2);
        check("b2b_last_gap", last_gap, 2);
        repeat (2) step();

        // Random commands with random ack latency.
        rc = rsp_cnt;
        rand_lat = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push(1'($urandom), 16'($urandom), 8'($urandom), 1'b0, 100, acc);
            check("rand_accept", acc, 1);
            n = int'($urandom_range(0, 2));
            repeat (n) step();
        end
        wait_drain(500);
        check("rand_rsp_count", rsp_cnt - rc, 24);
        rand_lat = 1'b0;
        repeat (2) step();

`ifdef WTS_INIT_TIMEOUT_EN
        // Unacknowledged read times out; the queued write then completes.
        slave_en = 1'b0;
        rc = rsp_cnt;
        push(1'b0, 16'h9880, 8'h00, 1'b1, 1, acc);
        push(1'b1, 16'h9801, 8'h77, 1'b0, 1, acc);
        wait_rsp(rc + 1, 200);
        check("to_req_len", last_req_len, 64);
        slave_lat = 1;
        slave_en  = 1'b1;
        wait_drain(50);
        check("to_next_req_len", last_req_len, 2);
`else
        // Without the timeout a long access simply waits for its ack.
        slave_lat = 80;
        push(1'b0, 16'h9880, 8'h00, 1'b0, 1, acc);
        wait_drain(200);
        check("long_req_len", last_req_len, 81);
        check("long_no_timeout", rsp_timeout, 0);
`endif
        repeat (2) step();

        // Reset during an access with two commands queued.
        slave_en = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b1, 16'h9900 + 16'(i), 8'hA0, 1'b0, 1, acc);
        n = 0;
        while (!req && n < 10) begin
            step();
            n++;
        end
        check("mid_req_high", req, 1);
        rc = rsp_cnt;
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_req", req, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        repeat (2) step();
        reset    = 1'b0;
        slave_en = 1'b1;
        slave_lat = 1;
        repeat (10) step();
        check("mid_no_rsp", rsp_cnt, rc);
        check("mid_req_idle", req, 0);
        check("mid_busy_idle", busy, 0);
        push(1'b1, 16'h9800, 8'h3C, 1'b0, 1, acc);
        wait_drain(50);
        check("post_rst_req_len", last_req_len, 2);
        repeat (2) step();

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
